// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch unit.
// Fetch FSM states, data width and the buffered fetch entry.
package if_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        END   = 2'd1,
        FAULT = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // pc+4 with one extra bit so a 32-bit wrap still reads as "too large"
    function automatic logic [XLEN:0] pc_plus4_ext(input logic [XLEN-1:0] pc);
        return {1'b0, pc} + (XLEN+1)'(4);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of instruction-memory, redirect and decode handshake signals.
// master = fetch unit, slave = the memory/decode/execute side.
interface inst_fetch_if;
    import if_pkg::*;

    logic [XLEN-1:0] mem_addr;
    logic            mem_nrd;
    logic [XLEN-1:0] mem_data;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            fault;

    modport master (
        output mem_addr, mem_nrd, inst_valid, inst, inst_pc, fault,
        input  mem_data, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_addr, mem_nrd, inst_valid, inst, inst_pc, fault,
        output mem_data, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of {pc, inst} fetch entries.
// Flush has priority over push/pop; the head entry is always on head_o.
module fetch_fifo
    import if_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [2];
    logic         wp_q, wp_d;
    logic         rp_q, rp_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_pop;

    assign do_pop = pop_i & (cnt_q != 2'd0);

    // next pointers and occupancy
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wp_d  = 1'b0;
            rp_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push_i) wp_d = ~wp_q;
            if (do_pop) rp_d = ~rp_q;
            cnt_d = cnt_q + {1'b0, push_i} - {1'b0, do_pop};
        end
    end

    // pointer and count registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // entry storage; cleared on reset so the head reads zero
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push_i && !flush_i) begin
            mem_q[wp_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rp_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch unit: owns the pc, reads memory, buffers two entries.
// Optional misaligned-redirect trap enabled by defining IF_ALIGN_CHECK_EN.
module inst_fetch
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     MEM_BYTES = 100
)
(
    input  logic        clk,
    input  logic        nrst,
    inst_fetch_if.master bus
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt;
    logic            misaligned;
    logic            end_hit;
    logic            pop;
    logic            rd;
    logic            flush;
    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    wentry;

`ifdef IF_ALIGN_CHECK_EN
    assign tgt        = bus.redirect_pc;
    assign misaligned = bus.redirect_pc[1:0] != 2'b00;
`else
    logic unused_lo;
    assign unused_lo  = ^bus.redirect_pc[1:0];
    assign tgt        = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign misaligned = 1'b0;
`endif

    assign end_hit = pc_plus4_ext(pc_q) > (XLEN+1)'(MEM_BYTES);
    assign pop     = bus.inst_valid & bus.inst_ready;

    // next-state, next-pc, read strobe and flush decode
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rd      = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (bus.redirect) begin
                    flush = 1'b1;
                    if (misaligned) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = tgt;
                        state_d = FETCH;
                    end
                end else if (end_hit) begin
                    state_d = END;
                end else if (count != 2'd2 || pop) begin
                    rd   = 1'b1;
                    pc_d = pc_q + XLEN'(4);
                end
            end
            END: begin
                if (bus.redirect) begin
                    flush = 1'b1;
                    if (misaligned) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = tgt;
                        state_d = FETCH;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // state and pc registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign wentry = '{pc: pc_q, inst: bus.mem_data};

    fetch_fifo u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (rd),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wentry),
        .head_o  (head),
        .count_o (count)
    );

    assign bus.mem_addr   = pc_q;
    assign bus.mem_nrd    = ~(rd & nrst);
    assign bus.inst_valid = count != 2'd0;
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;
`ifdef IF_ALIGN_CHECK_EN
    assign bus.fault      = state_q == FAULT;
`else
    assign bus.fault      = 1'b0;
`endif

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch initiator for the byte-addressed, big-endian instruction memory. Owns the program counter, drives the memory's address and active-low read strobe, captures each returned 32-bit word together with its PC into a 2-entry buffer, and presents instructions to decode over a valid/ready handshake. Sits between the instruction memory and the decode stage, and accepts branch/jump redirects from execute.

## Interface
- RESET_PC, 32'h0000_0000 — PC loaded on reset.
- MEM_BYTES, 100 — instruction memory size in bytes; no fetch is issued at or beyond it.
- clk  in  1  rising-edge clock.
- nrst  in  1  asynchronous, active-low reset.
- mem_addr  out  32  byte address of current fetch; equals pc.
- mem_nrd  out  1  read strobe; 0 = read this cycle, 1 = idle.
- mem_data  in  32  big-endian word from memory, valid in the same cycle as mem_nrd=0.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target.
- inst_valid  out  1  buffer head holds a valid instruction.
- inst_ready  in  1  decode consumes head when inst_valid & inst_ready.
- inst  out  32  head instruction word.
- inst_pc  out  32  PC of head instruction.
- fault  out  1  misaligned redirect target (IF_ALIGN_CHECK_EN only; otherwise tied 0).

## Operation
- States: FETCH, END, FAULT. Reset enters FETCH.
- FETCH: mem_nrd=0 when buffer count<2, or count==2 and a pop occurs this cycle; and redirect=0. On that edge, push {pc, mem_data} and pc<=pc+4.
- End of memory: if pc+4 > MEM_BYTES in FETCH, mem_nrd=1 and state->END. END issues no reads; the buffer drains normally.
- Redirect (any state except FAULT): at the edge, flush buffer (count<=0), pc<=redirect_pc, state->FETCH. No push in the redirect cycle; a simultaneous pop is discarded.
- Buffer: 2-entry FIFO, head on outputs. Push+pop at the same edge keeps count; a push into a full buffer never occurs by construction.
- pc arithmetic is 32-bit modulo 2^32. Wrap makes pc small, so it is caught by the MEM_BYTES check only if the check is done before the increment; implement the check before the increment.
- mem_addr is always pc. When mem_nrd=1, mem_data is ignored (it may be Z).

## Timing
- Reset values: pc=RESET_PC, count=0, inst_valid=0, inst=0, inst_pc=0, mem_nrd=1 during reset, fault=0, state FETCH.
- Reset release to first inst_valid: 1 cycle. The first edge after nrst rises fetches RESET_PC.
- Redirect to first new inst_valid: 2 cycles. inst_valid is 0 in the cycle after redirect.
- Sustained throughput: 1 instruction/cycle with inst_ready held high.
- inst_ready low with count=2: mem_nrd=1 and pc holds until a pop occurs.
- nrst asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

## Configuration
- IF_ALIGN_CHECK_EN defined: when redirect occurs with redirect_pc[1:0]!=0, flush, set fault=1, enter FAULT. FAULT issues no reads and ignores redirect; only nrst exits it.
- IF_ALIGN_CHECK_EN undefined: redirect_pc[1:0] is forced to 2'b00, fault is constant 0, and no FAULT state exists.

## Structure
- Package if_pkg holds the state enum (FETCH, END, FAULT), the XLEN=32 constant, and the fetch-entry struct {pc, inst}.
- Sub-module fetch_fifo: 2-entry synchronous FIFO of fetch entries with push/pop/flush, count, and head outputs. It has the same clk/nrst as this block.

## Test plan
- Reset release, inst_ready=1, memory bytes 00..0F = 00 11 22 33 44 55 66 77 … -> inst=32'h00112233 at inst_pc=0, then 32'h44556677 at 4, one instruction per cycle.
- Hold inst_ready=0 for 5 cycles -> exactly 2 fetches complete, mem_nrd=1 afterwards, pc=8; raise inst_ready -> entries 0 and 4 are delivered, then 8.
- Redirect to 32'h20 while count=2 -> buffer flushed, inst_valid=0 the next cycle, inst_pc=32'h20 valid 2 cycles after the redirect.
- MEM_BYTES=100, run to the end -> last delivered inst_pc=96, state END, mem_nrd stays 1; a redirect to 0 resumes fetch.
- Redirect to 32'h22 -> with IF_ALIGN_CHECK_EN: fault=1, no reads, and a later redirect is ignored. Without the macro: fetch resumes from 32'h20.
- Assert nrst mid-stream with count=1 -> inst_valid=0, pc=RESET_PC, and mem_nrd=1 asynchronously.
